// File: rtl/reg_file_pkg.sv
// Shared widths and helpers for the architectural register file.
// Default widths match the core's data and register-name widths.
package reg_file_pkg;

  localparam int RF_WORD = 16;
  localparam int RF_W_RD = 3;

  // True when a register name refers to the hard-wired zero register.
  function automatic logic is_zero_name(input logic [RF_W_RD-1:0] name, input int zero_reg);
    return (zero_reg != 0) && (name == '0);
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file between ID and EX: one write port, two
// combinational read ports with write-back bypass, and a pending-write scoreboard.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WORD     = RF_WORD,
  parameter int W_RD     = RF_W_RD,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_i,
  input  logic [W_RD-1:0] wb_rd_name_i,
  input  logic [WORD-1:0] wb_rd_data_i,
  input  logic [W_RD-1:0] src_name_i,
  input  logic [W_RD-1:0] dest_name_i,
  output logic [WORD-1:0] src_o,
  output logic [WORD-1:0] dest_o,
  input  logic            issue_i,
  input  logic [W_RD-1:0] issue_rd_i,
  output logic            hazard_o
);

  localparam int NREG = 1 << W_RD;

  logic [WORD-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic            wb_en;
  logic            issue_en;
  logic            busy_src;
  logic            busy_dest;

  function automatic logic zero_name(input logic [W_RD-1:0] name);
    return (ZERO_REG != 0) && (name == '0);
  endfunction

  // Read/bypass mux: the in-flight write-back wins over the stored value.
  function automatic logic [WORD-1:0] rf_read(
    input logic [W_RD-1:0] name,
    input logic [WORD-1:0] stored,
    input logic            wr_en,
    input logic [W_RD-1:0] wr_name,
    input logic [WORD-1:0] wr_data
  );
    if (zero_name(name))
      return '0;
    else if (wr_en && (wr_name == name))
      return wr_data;
    else
      return stored;
  endfunction

  function automatic logic rf_busy(
    input logic [W_RD-1:0] name,
    input logic            pend,
    input logic            wr_en,
    input logic [W_RD-1:0] wr_name
  );
    return pend && !(wr_en && (wr_name == name));
  endfunction

  // Gating with rst keeps the bypass from leaking write data while in reset.
  assign wb_en    = rst && wb_i && !zero_name(wb_rd_name_i);
  assign issue_en = issue_i && !zero_name(issue_rd_i);

  assign src_o     = rf_read(src_name_i,  regs[src_name_i],  wb_en, wb_rd_name_i, wb_rd_data_i);
  assign dest_o    = rf_read(dest_name_i, regs[dest_name_i], wb_en, wb_rd_name_i, wb_rd_data_i);
  assign busy_src  = rf_busy(src_name_i,  pending[src_name_i],  wb_en, wb_rd_name_i);
  assign busy_dest = rf_busy(dest_name_i, pending[dest_name_i], wb_en, wb_rd_name_i);
  assign hazard_o  = busy_src || busy_dest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_rd_name_i] <= wb_rd_data_i;
    end
  end

  // Set after clear: a new producer issued alongside the old write-back keeps the bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (issue_en && (issue_rd_i == W_RD'(i)))
          pending[i] <= 1'b1;
        else if (wb_i && (wb_rd_name_i == W_RD'(i)))
          pending[i] <= 1'b0;
      end
    end
  end

endmodule
